lsu_mem_initiator: RTL and testbench

- Processor-side load/store initiator for the word-addressed data memory.
- Accepts one load/store per handshake from the execute stage.
- Converts the byte address and funct3 into a word address, byte enables and lane-replicated store data.
- Drives a request/ready bus to memory, then returns a sign- or zero-extended load result or a fault code.
- Holds `busy` high to stall the core while an access is outstanding.

---
 rtl/lsu_mem_initiator.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: decodes a core request into a word-addressed memory access,
// waits for mem_ready with a timeout, and returns an extended load result or fault code.
module lsu_mem_initiator #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state, state_nx;
    logic [7:0]         cnt;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [1:0]         err_q;

    logic               accept, legal, misal, expire;
    logic [1:0]         dec_err;
    logic [3:0]         dec_be;
    logic [31:0]        dec_wdata, lane, load_val;
    logic               unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_req    = (state == S_BUS);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? addr_q  : '0;
    assign mem_be     = mem_req ? be_q    : '0;
    assign mem_wdata  = mem_req ? wdata_q : '0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept = req_valid && req_ready;
    assign expire = (cnt == CNT_LAST);

    // Request decode; funct3[1:0] encodes the access size for every legal op.
    always_comb begin
        legal     = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        dec_err   = !legal ? 2'b10 : (misal ? 2'b01 : 2'b00);
        dec_be    = 4'b1111;
        dec_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                dec_be    = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                dec_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (dec_err == 2'b00) ? S_BUS : S_RESP;
            S_BUS:  if (mem_ready || expire) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        we_q    <= req_store;
                        addr_q  <= req_addr[ADDR_W+1:2];
                        be_q    <= dec_be;
                        wdata_q <= req_store ? dec_wdata : 32'd0;
                        if (dec_err != 2'b00) begin
                            rdata_q <= '0;
                            err_q   <= dec_err;
                        end
                    end
                end
                S_BUS: begin
                    cnt <= cnt + 8'd1;
                    // ready on the expiry cycle still completes the access
                    if (mem_ready) begin
                        rdata_q <= we_q ? 32'd0 : load_val;
                        err_q   <= 2'b00;
                    end else if (expire) begin
                        rdata_q <= '0;
                        err_q   <= 2'b11;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized and directed bench for lsu_mem_initiator against a per-transaction
// timeline model (bus cycle count, response cycle and result computed at accept).
module tb_lsu_mem_initiator;
    localparam int TO = 15;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_store = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, busy, resp_valid, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_wdata;
    logic [1:0]  resp_err;
    logic [5:0]  mem_addr;
    logic [3:0]  mem_be;
    logic        mem_ready = 0;
    logic [31:0] mem_rdata = 0;

    lsu_mem_initiator #(.ADDR_W(6), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] p_rdata;
    int          p_rdy;
    bit          m_active = 0;
    int          m_t = 0, m_nb = 0;
    logic [31:0] m_rd = 0, m_last_rd = 0, m_wd = 0;
    logic [1:0]  m_err = 0, m_last_err = 0;
    logic [3:0]  m_be = 0;
    logic [5:0]  m_addr = 0;
    bit          m_we = 0;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] rd, input int off);
        logic [31:0] lane, v;
        lane = rd >> (8 * off);
        case (f3)
            3'b000: begin v = lane & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3'b001: begin v = lane & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'b100: v = lane & 32'hFF;
            3'b101: v = lane & 32'hFFFF;
            default: v = lane;
        endcase
        return v;
    endfunction

    task automatic model_accept();
        int sz, off;
        bit legal;
        logic [1:0] e;
        sz  = 1 << req_funct3[1:0];
        off = int'(req_addr % 4);
        legal = req_store ? (req_funct3 <= 3'd2)
                          : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e = !legal ? 2'b10 : ((off % sz) != 0) ? 2'b01 : 2'b00;
        m_we   = req_store;
        m_addr = 6'((req_addr / 4) % 64);
        m_be   = 4'(((1 << sz) - 1) << off);
        m_wd   = !req_store ? 32'd0 :
                 (sz == 1) ? (req_wdata & 32'hFF) * 32'h01010101 :
                 (sz == 2) ? (req_wdata & 32'hFFFF) * 32'h00010001 : req_wdata;
        if (e != 2'b00) begin
            m_nb = 0; m_err = e; m_rd = 0;
        end else if (p_rdy >= 1 && p_rdy <= TO) begin
            m_nb = p_rdy; m_err = 0;
            m_rd = req_store ? 32'd0 : extract(req_funct3, p_rdata, off);
        end else begin
            m_nb = TO; m_err = 2'b11; m_rd = 0;
        end
        m_active = 1; m_t = 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_last_rd = 0; m_last_err = 0;
        end else if (m_active) begin
            if (m_t == m_nb + 1) begin
                m_active = 0; m_last_rd = m_rd; m_last_err = m_err;
            end else m_t++;
        end else if (req_valid) model_accept();
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit ereq, eresp;
            ereq  = m_active && (m_t <= m_nb);
            eresp = m_active && (m_t == m_nb + 1);
            chk("req_ready", 32'(req_ready), 32'(!m_active));
            chk("busy", 32'(busy), 32'(m_active));
            chk("mem_req", 32'(mem_req), 32'(ereq));
            chk("resp_valid", 32'(resp_valid), 32'(eresp));
            chk("resp_rdata", resp_rdata, eresp ? m_rd : m_last_rd);
            chk("resp_err", 32'(resp_err), 32'(eresp ? m_err : m_last_err));
            if (ereq) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_be", 32'(mem_be), 32'(m_be));
                chk("mem_wdata", mem_wdata, m_wd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                          input int rdy, input bit lb, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [5:0] eaddr, input bit ewe,
                          input bit lr, input logic [31:0] erd, input logic [1:0] eerr,
                          input int enreq);
        int nrq, nb;
        @(negedge clk);
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        mem_rdata = rd; p_rdata = rd; p_rdy = rdy;
        mem_ready = 1'($urandom % 2);
        @(posedge clk);
        nrq = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nb = m_nb;
            req_valid = 1'($urandom % 2); req_store = 1'($urandom % 2);
            req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            mem_ready = (k <= nb) ? (k == rdy) : 1'($urandom % 2);
            if (mem_req) nrq++;
            if (lb && k == 1) begin
                chk("lit_mem_be", 32'(mem_be), 32'(ebe));
                chk("lit_mem_wdata", mem_wdata, ewd);
                chk("lit_mem_addr", 32'(mem_addr), 32'(eaddr));
                chk("lit_mem_we", 32'(mem_we), 32'(ewe));
            end
            if (k == nb + 1) begin
                if (lr) begin
                    chk("lit_resp_valid", 32'(resp_valid), 32'd1);
                    chk("lit_resp_rdata", resp_rdata, erd);
                    chk("lit_resp_err", 32'(resp_err), 32'(eerr));
                end
                break;
            end
        end
        if (enreq >= 0) chk("lit_mem_req_cycles", 32'(nrq), 32'(enreq));
        @(negedge clk);
        req_valid = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", {busy, resp_valid, mem_req, mem_we, resp_err, mem_be, mem_addr},
            32'd0);
        chk("rst_data", resp_rdata | mem_wdata, 32'd0);
        chk_en = 1;

        // directed, with literal expectations
        do_txn(0, 3'b010, 32'h8, 0, 32'h19, 1, 1, 4'hF, 0, 6'd2, 0, 1, 32'h19, 2'b00, 1);
        do_txn(0, 3'b000, 32'h7, 0, 32'h80FFFFFF, 2, 0, 0, 0, 0, 0, 1, 32'hFFFFFF80, 2'b00, 2);
        do_txn(0, 3'b100, 32'h7, 0, 32'h80FFFFFF, 1, 0, 0, 0, 0, 0, 1, 32'h00000080, 2'b00, -1);
        do_txn(0, 3'b101, 32'h6, 0, 32'h80FFFFFF, 1, 0, 0, 0, 0, 0, 1, 32'h000080FF, 2'b00, -1);
        do_txn(0, 3'b001, 32'h2, 0, 32'h8001FFFF, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF8001, 2'b00, -1);
        do_txn(1, 3'b000, 32'h5, 32'h000000AB, 0, 1, 1, 4'b0010, 32'hABABABAB, 6'd1, 1,
               1, 32'h0, 2'b00, 1);
        do_txn(1, 3'b001, 32'hA, 32'h00001234, 0, 3, 1, 4'b1100, 32'h12341234, 6'd2, 1,
               1, 32'h0, 2'b00, 3);
        do_txn(0, 3'b010, 32'h104, 0, 32'h55, 1, 1, 4'hF, 0, 6'd1, 0, 1, 32'h55, 2'b00, 1);
        do_txn(0, 3'b010, 32'h6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 2'b01, 0);
        do_txn(1, 3'b011, 32'h1, 32'hFF, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 2'b10, 0);
        do_txn(0, 3'b010, 32'h20, 0, 32'hCAFE, 0, 0, 0, 0, 0, 0, 1, 32'h0, 2'b11, 15);
        do_txn(0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 15, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 2'b00, 15);

        // reset during the bus wait
        @(negedge clk);
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        p_rdy = 0; p_rdata = 0; mem_ready = 0;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 0; mem_ready = 0;
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'($urandom % 2);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_txn(0, 3'b010, 32'h3C, 0, 32'h1234ABCD, 1, 1, 4'hF, 0, 6'd15, 0,
               1, 32'h1234ABCD, 2'b00, 1);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            bit st;
            logic [2:0] f3;
            int rdy;
            st = 1'($urandom % 2);
            if ($urandom % 4 == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            rdy = ($urandom % 5 == 0) ? $urandom_range(0, 17) : $urandom_range(1, 3);
            do_txn(st, f3, (($urandom % 3) == 0) ? $urandom : ($urandom & 32'h3F & ~32'h0)
                   & (($urandom % 2) ? 32'hFFFFFFFF : 32'hFFFFFFFC),
                   $urandom, $urandom, rdy, 0, 0, 0, 0, 0, 0, 0, 0, -1);
            if ($urandom % 3 == 0) repeat ($urandom_range(1, 2)) begin
                @(negedge clk);
                mem_ready = 1'($urandom % 2);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
